sync_fifo_fwft: RTL

Single-clock first-word-fall-through FIFO that sits between the AXI FIFO bridge write side and its read side (or behind either side alone), buffering 32-bit words written over AXI4-Lite. The head word is always presented on `rd_data` while `empty` is low, so the bridge can capture it in the same cycle it pulses `rd_en`. It provides full, empty and threshold flags plus an occupancy count, and optionally sticky overflow and underflow error flags.

---
 rtl/sync_fifo_fwft.sv | 96 +++++++++
 1 files changed

// File: rtl/sync_fifo_fwft.sv
// Single-clock first-word-fall-through FIFO; the head word is on rd_data one cycle after its write, and flags decode from a registered count.
// Writes while full and reads while empty are dropped; define SYNC_FIFO_ERR_FLAGS_EN for sticky overflow/underflow flags with err_clr.
module sync_fifo_fwft #(
  parameter int DATA_WIDTH          = 32,
  parameter int ADDR_WIDTH          = 4,
  parameter int ALMOST_FULL_THRESH  = 14,
  parameter int ALMOST_EMPTY_THRESH = 2
) (
  input  logic                  aclk,
  input  logic                  aresetn,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  wr_en,
  output logic                  full,
  output logic                  almost_full,
  output logic [DATA_WIDTH-1:0] rd_data,
  input  logic                  rd_en,
  output logic                  empty,
  output logic                  almost_empty,
  output logic [ADDR_WIDTH:0]   count
`ifdef SYNC_FIFO_ERR_FLAGS_EN
  ,
  input  logic                  err_clr,
  output logic                  overflow,
  output logic                  underflow
`endif
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] DEPTH_C = (ADDR_WIDTH + 1)'(DEPTH);
  localparam logic [ADDR_WIDTH:0] AF_C    = (ADDR_WIDTH + 1)'(ALMOST_FULL_THRESH);
  localparam logic [ADDR_WIDTH:0] AE_C    = (ADDR_WIDTH + 1)'(ALMOST_EMPTY_THRESH);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [ADDR_WIDTH-1:0] wp;
  logic [ADDR_WIDTH-1:0] rp;
  logic                  wr_ok;
  logic                  rd_ok;

  assign wr_ok = wr_en & ~full;
  assign rd_ok = rd_en & ~empty;

  // Storage is never reset; pointers alone define which entries are live.
  always_ff @(posedge aclk) begin
    if (wr_ok) begin
      mem[wp] <= wr_data;
    end
  end

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      wp    <= '0;
      rp    <= '0;
      count <= '0;
    end else begin
      if (wr_ok) begin
        wp <= wp + 1'b1;
      end
      if (rd_ok) begin
        rp <= rp + 1'b1;
      end
      case ({wr_ok, rd_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  assign rd_data      = mem[rp];
  assign full         = (count == DEPTH_C);
  assign empty        = (count == '0);
  assign almost_full  = (count >= AF_C);
  assign almost_empty = (count <= AE_C);

`ifdef SYNC_FIFO_ERR_FLAGS_EN
  // Set is applied after clear so a same-edge set wins.
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (err_clr) begin
        overflow  <= 1'b0;
        underflow <= 1'b0;
      end
      if (wr_en & full) begin
        overflow <= 1'b1;
      end
      if (rd_en & empty) begin
        underflow <= 1'b1;
      end
    end
  end
`endif

endmodule
